gb_cart_bus_master: RTL and testbench

//   Host-side initiator for the Game Boy cartridge bus: the console end that drives the cart ROM/MBC responder.
//   - Turns single-beat read/write requests into timed cycles on the bus: address, nRD/nWR/nCS strobes, 8-bit data.
//   - Used for cart dumping/flashing and as a stimulus source for responder-side logic.
//   - Runs from the 48 MHz SB_HFOSC clock.

---
 rtl/gb_cart_bus_master_pkg.sv | 14 +
 rtl/gb_cart_bus_master_timer.sv | 17 +
 rtl/gb_cart_bus_master.sv | 102 ++++++++++
 tb/tb_gb_cart_bus_master.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/gb_cart_bus_master_pkg.sv
// gb_cart_bus_master_pkg: FSM encodings and cartridge address map shared by the bus master
package gb_cart_bus_master_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_e;
  localparam logic [15:0] ROM0_BASE = 16'h0000;
  localparam logic [15:0] ROM0_END  = 16'h3FFF;
  localparam logic [15:0] ROMX_BASE = 16'h4000;
  localparam logic [15:0] ROMX_END  = 16'h7FFF;
  localparam logic [15:0] SRAM_BASE = 16'hA000;
  localparam logic [15:0] SRAM_END  = 16'hBFFF;
  localparam logic [15:0] ECHO_END  = 16'hFDFF;
  function automatic logic ncs_window(input logic [15:0] a);
    return a >= SRAM_BASE && a <= ECHO_END;
  endfunction
endpackage

// File: rtl/gb_cart_bus_master_timer.sv
// gb_cart_bus_master_timer: loadable down-counter with a zero flag, stops at zero
module gb_cart_bus_master_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // load wins over counting; counter parks at zero
  always_comb cnt_d = load_i ? val_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/gb_cart_bus_master.sv
// gb_cart_bus_master: Game Boy cartridge bus initiator; define GB_NCS_DECODE_EN to decode cart_ncs for A000..FDFF
module gb_cart_bus_master
  import gb_cart_bus_master_pkg::*;
#(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 6,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] cart_addr,
  inout  tri   [7:0]  cart_data,
  output logic        cart_nrd,
  output logic        cart_nwr,
  output logic        cart_ncs,
  output logic        cart_oe
);
  localparam int MAXC = SETUP_CYCLES > STROBE_CYCLES ?
                        (SETUP_CYCLES > HOLD_CYCLES ? SETUP_CYCLES : HOLD_CYCLES) :
                        (STROBE_CYCLES > HOLD_CYCLES ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CW = $clog2(MAXC) + 1;
  state_e state_q, state_d;
  logic load, zero, strobe;
  logic [CW-1:0] load_val;
  logic [15:0] addr_q;
  logic [7:0] wdata_q, rdata_q;
  logic write_q, rsp_valid_q;
  gb_cart_bus_master_timer #(.W(CW)) u_timer (
    .clk(clk),
    .rst(rst),
    .load_i(load),
    .val_i(load_val),
    .zero_o(zero)
  );
  // state register
  always_ff @(posedge clk) state_q <= rst ? ST_IDLE : state_d;
  // next state and timer reload on every state entry
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    load_val = CW'(SETUP_CYCLES - 1);
    case (state_q)
      ST_IDLE: if (req_valid) begin
        state_d = ST_SETUP;
        load = 1'b1;
      end
      ST_SETUP: if (zero) begin
        state_d = ST_STROBE;
        load = 1'b1;
        load_val = CW'(STROBE_CYCLES - 1);
      end
      ST_STROBE: if (zero) begin
        state_d = ST_HOLD;
        load = 1'b1;
        load_val = CW'(HOLD_CYCLES - 1);
      end
      default: if (zero) state_d = ST_IDLE;
    endcase
  end
  // request capture, read-data sampling at the end of STROBE, completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && req_valid) begin
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        write_q <= req_write;
      end
      if (state_q == ST_STROBE && zero && !write_q) rdata_q <= cart_data;
      rsp_valid_q <= state_q == ST_HOLD && zero;
    end
  end
  // bus strobes and direction decoded from state and captured request
  always_comb begin
    strobe = state_q == ST_STROBE;
    req_ready = state_q == ST_IDLE && !rst;
    cart_nrd = !(strobe && !write_q);
    cart_nwr = !(strobe && write_q);
    cart_oe = write_q && state_q != ST_IDLE;
`ifdef GB_NCS_DECODE_EN
    cart_ncs = !(strobe && ncs_window(addr_q));
`else
    cart_ncs = 1'b1;
`endif
  end
  assign cart_data = cart_oe ? wdata_q : 8'hzz;
  assign cart_addr = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
endmodule

// File: tb/tb_gb_cart_bus_master.sv
// tb_gb_cart_bus_master: directed self-checking bench for the cartridge bus master
module tb_gb_cart_bus_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic req_ready, rsp_valid, cart_nrd, cart_nwr, cart_ncs, cart_oe;
  logic [7:0] rsp_rdata;
  logic [15:0] cart_addr;
  logic [7:0] cart_byte = 8'h00;
  tri [7:0] cart_data;
  int n_assert = 0;
  int n_fail = 0;
  int nrd_low, nrd_first, nwr_low, nwr_first, ncs_low, oe_cnt, data_ok;
  int addr_bad, strobe_bad, overlap, rsp_cnt, rsp_k;
  logic start_ready, start_rsp, start_strobe;

  always #5 clk = ~clk;
  assign cart_data = cart_nrd ? 8'hzz : cart_byte;

  gb_cart_bus_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cart_addr(cart_addr), .cart_data(cart_data),
    .cart_nrd(cart_nrd), .cart_nwr(cart_nwr), .cart_ncs(cart_ncs), .cart_oe(cart_oe)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // issue one request at a negedge, then observe the 11 cycles after the accept edge
  task automatic xfer(input logic w, input logic [15:0] a, input logic [7:0] d);
    start_ready = req_ready;
    start_rsp = rsp_valid;
    start_strobe = !cart_nrd || !cart_nwr;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b1; req_addr = ~a; req_write = !w;
    nrd_low = 0; nrd_first = 0; nwr_low = 0; nwr_first = 0; ncs_low = 0; oe_cnt = 0;
    data_ok = 0; addr_bad = 0; strobe_bad = 0; overlap = 0; rsp_cnt = 0; rsp_k = 0;
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 10) req_valid = 1'b0;
      if (!cart_nrd) begin nrd_low++; if (nrd_first == 0) nrd_first = k; end
      if (!cart_nwr) begin nwr_low++; if (nwr_first == 0) nwr_first = k; end
      if (!cart_ncs) ncs_low++;
      if (cart_oe) begin oe_cnt++; if (cart_data === d) data_ok++; end
      if (k <= 10 && cart_addr !== a) addr_bad++;
      if ((!cart_nrd || !cart_nwr) && (k < 3 || k > 8)) strobe_bad++;
      if (!cart_nrd && !cart_nwr) overlap++;
      if (rsp_valid) begin rsp_cnt++; rsp_k = k; end
    end
    req_valid = 1'b0;
  endtask

  task automatic chk_read(input string t, input logic [7:0] exp_rd);
    chk({t, "_ready"}, start_ready, 1);
    chk({t, "_nrd_cycles"}, nrd_low, 6);
    chk({t, "_nrd_first"}, nrd_first, 3);
    chk({t, "_nwr_cycles"}, nwr_low, 0);
    chk({t, "_oe_cycles"}, oe_cnt, 0);
    chk({t, "_addr_unstable"}, addr_bad, 0);
    chk({t, "_strobe_outside"}, strobe_bad, 0);
    chk({t, "_rsp_count"}, rsp_cnt, 1);
    chk({t, "_rsp_latency"}, rsp_k, 11);
    chk({t, "_rdata"}, rsp_rdata, exp_rd);
  endtask

  initial begin
    // 1 reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_nrd", cart_nrd, 1);
    chk("rst_nwr", cart_nwr, 1);
    chk("rst_ncs", cart_ncs, 1);
    chk("rst_oe", cart_oe, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 8'h00);
    chk("rst_addr", cart_addr, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", req_ready, 1);
    // 2 read 0134
    cart_byte = 8'h50;
    xfer(1'b0, 16'h0134, 8'hEE);
    chk_read("rd0134", 8'h50);
    chk("rd0134_ncs", ncs_low, 0);
    // 3 write A5 to 2000; read data register must hold
    cart_byte = 8'h77;
    xfer(1'b1, 16'h2000, 8'hA5);
    chk("wr_ready", start_ready, 1);
    chk("wr_oe_cycles", oe_cnt, 10);
    chk("wr_data_cycles", data_ok, 10);
    chk("wr_nwr_cycles", nwr_low, 6);
    chk("wr_nwr_first", nwr_first, 3);
    chk("wr_nrd_cycles", nrd_low, 0);
    chk("wr_addr_unstable", addr_bad, 0);
    chk("wr_strobe_outside", strobe_bad, 0);
    chk("wr_rsp_count", rsp_cnt, 1);
    chk("wr_rsp_latency", rsp_k, 11);
    chk("wr_rdata_held", rsp_rdata, 8'h50);
    // 4 back-to-back reads
    cart_byte = 8'hC3;
    xfer(1'b0, 16'h0000, 8'h00);
    chk_read("rd0000", 8'hC3);
    cart_byte = 8'h3C;
    xfer(1'b0, 16'h7FFF, 8'h00);
    chk("b2b_rsp_at_accept", start_rsp, 1);
    chk("b2b_no_strobe_at_accept", start_strobe, 0);
    chk_read("rd7FFF", 8'h3C);
    chk("b2b_overlap", overlap, 0);
    // 5 reset during STROBE of a write
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h2100; req_wdata = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_nwr", cart_nwr, 0);
    chk("abort_pre_oe", cart_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_nwr", cart_nwr, 1);
    chk("abort_oe", cart_oe, 0);
    chk("abort_rsp", rsp_valid, 0);
    chk("abort_addr", cart_addr, 16'h0000);
    rst = 1'b0;
    rsp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    chk("abort_no_rsp", rsp_cnt, 0);
    chk("abort_ready", req_ready, 1);
    cart_byte = 8'h99;
    xfer(1'b0, 16'h0150, 8'h00);
    chk_read("rd0150", 8'h99);
    // 6 chip-select decode
    cart_byte = 8'h11;
    xfer(1'b0, 16'hA000, 8'h00);
    chk_read("rdA000", 8'h11);
`ifdef GB_NCS_DECODE_EN
    chk("ncs_A000", ncs_low, 6);
`else
    chk("ncs_A000", ncs_low, 0);
`endif
    cart_byte = 8'h22;
    xfer(1'b0, 16'h4000, 8'h00);
    chk_read("rd4000", 8'h22);
    chk("ncs_4000", ncs_low, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
